// File: rtl/gps_accum_reader.sv
// Wishbone read master that snapshots the correlator accumulator window on each
// accum_int rising edge into a 12-word buffer readable through rd_adr/rd_dat.
module gps_accum_reader #(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        correlator_clk,
  input  logic        rstn,
  input  logic        accum_int,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [3:0]  rd_adr,
  output logic [31:0] rd_dat,
  output logic        irq,
  input  logic        irq_clr,
  output logic        busy,
  output logic        err,
  output logic [7:0]  overrun_cnt
);
  localparam int         NSTEP     = 12;
  localparam int         CW        = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST_STEP = 4'(NSTEP - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    step_q;
  logic [CW-1:0] cnt_q;
  logic          acc_q;
  logic          acc_rise;
  logic [31:0]   buf_q [16];

  logic          bus_act;
  logic          buf_we;
  logic          step_clr;
  logic          step_inc;
  logic          err_set;
  logic          irq_set;
  logic          timeout_hit;
  logic [3:0]    buf_idx;
  logic [7:0]    word_adr;

  // STATUS/NEW_DATA come first on the bus but live at the top of the buffer
  always_comb begin
    word_adr = 8'({4'h0, step_q}) + 8'd2;
    buf_idx  = step_q - 4'd2;
    case (step_q)
      4'd0: begin word_adr = 8'hE0; buf_idx = 4'd10; end
      4'd1: begin word_adr = 8'hE1; buf_idx = 4'd11; end
      default: ;
    endcase
  end

  assign acc_rise    = accum_int & ~acc_q;
  assign timeout_hit = (cnt_q >= CW'(TIMEOUT - 1));

  always_ff @(posedge correlator_clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    bus_act  = 1'b0;
    buf_we   = 1'b0;
    step_clr = 1'b0;
    step_inc = 1'b0;
    err_set  = 1'b0;
    irq_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_rise) begin
          step_clr = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        bus_act = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        bus_act = 1'b1;
        if (wbm_ack_i) begin
          buf_we  = 1'b1;
          state_d = GAP;
        end else if (timeout_hit) begin
          err_set = 1'b1;
          state_d = DONE;
        end
      end
      GAP: begin
        // NEW_DATA bit 0 clear means nothing fresh: keep the old I/Q words
        if ((step_q == 4'd1 && !buf_q[11][0]) || step_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          step_inc = 1'b1;
          state_d  = REQ;
        end
      end
      DONE: begin
        irq_set = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge correlator_clk) begin
    if (!rstn) begin
      acc_q       <= 1'b0;
      step_q      <= '0;
      cnt_q       <= '0;
      irq         <= 1'b0;
      err         <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      acc_q <= accum_int;
      if (step_clr)      step_q <= '0;
      else if (step_inc) step_q <= step_q + 4'd1;
      // counter counts stb-high cycles, REQ being the first
      if (state_q == REQ)                          cnt_q <= CW'(1);
      else if (state_q == WAIT_ACK && !timeout_hit) cnt_q <= cnt_q + CW'(1);
      if (irq_set)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
      if (err_set)                 err <= 1'b1;
      else if (irq_clr && !irq_set) err <= 1'b0;
      if (acc_rise && state_q != IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  always_ff @(posedge correlator_clk) begin
    for (int i = 0; i < 16; i++) begin
      if (!rstn)                           buf_q[i] <= '0;
      else if (buf_we && buf_idx == 4'(i)) buf_q[i] <= wbm_dat_i;
    end
  end

  assign wbm_cyc_o = bus_act;
  assign wbm_stb_o = bus_act;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = bus_act ? BASE_ADR + {22'd0, word_adr, 2'b00} : '0;
  assign busy      = (state_q != IDLE);
  assign rd_dat    = (rd_adr < 4'(NSTEP)) ? buf_q[rd_adr] : '0;

endmodule

// File: tb/tb_gps_accum_reader.sv
// Directed bench for gps_accum_reader: behavioural Wishbone responder plus a
// negedge bus monitor; expected values are hand-computed per scenario.
module tb_gps_accum_reader;
  logic        correlator_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        accum_int = 1'b0;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i = 1'b0;
  logic [3:0]  rd_adr = '0;
  logic [31:0] rd_dat;
  logic        irq;
  logic        irq_clr = 1'b0;
  logic        busy, err;
  logic [7:0]  overrun_cnt;

  gps_accum_reader #(.BASE_ADR(32'h0000_0000), .TIMEOUT(16)) dut (
    .correlator_clk(correlator_clk), .rstn(rstn), .accum_int(accum_int),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i), .rd_adr(rd_adr), .rd_dat(rd_dat), .irq(irq),
    .irq_clr(irq_clr), .busy(busy), .err(err), .overrun_cnt(overrun_cnt)
  );

  always #5 correlator_clk = ~correlator_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // responder: acks on the third clock of stb, data looked up by word address
  logic        ack_en = 1'b1;
  logic [31:0] status_v, newdata_v;
  logic [31:0] iq [10];
  int          scnt = 0;

  function automatic logic [31:0] resp_dat(input logic [31:0] a);
    logic [7:0] w;
    w = a[9:2];
    if (w == 8'hE0) return status_v;
    if (w == 8'hE1) return newdata_v;
    if (w >= 8'd4 && w <= 8'd13) return iq[w - 8'd4];
    return 32'hBAD0_BAD0;
  endfunction

  always @(posedge correlator_clk) begin
    wbm_ack_i <= 1'b0;
    if (!wbm_stb_o || wbm_ack_i) scnt <= 0;
    else if (ack_en && scnt == 2) begin
      wbm_ack_i <= 1'b1;
      wbm_dat_i <= resp_dat(wbm_adr_o);
      scnt      <= 0;
    end else scnt <= scnt + 1;
  end

  // bus monitor
  int          tcnt = 0, nreq = 0, nack = 0, hi_run = 0, last_hi = 0;
  int          last_ack_t = 0, gap_bad = 0, lo_run = 0;
  bit          lo_valid = 0, stb_prev = 0;
  logic [31:0] adr_q [$];

  always @(negedge correlator_clk) begin
    if (wbm_stb_o) hi_run <= hi_run + 1;
    else begin
      if (stb_prev) last_hi <= hi_run;
      hi_run <= 0;
    end
    if (!wbm_stb_o) lo_run <= stb_prev ? 1 : lo_run + 1;
    if (!wbm_stb_o && stb_prev) lo_valid <= 1;
    if (wbm_stb_o && !stb_prev) begin
      nreq <= nreq + 1;
      if (lo_valid && lo_run != 1) gap_bad <= gap_bad + 1;
    end
    if (wbm_stb_o && wbm_ack_i) begin
      nack       <= nack + 1;
      last_ack_t <= tcnt;
      adr_q.push_back(wbm_adr_o);
    end
    if (!busy) lo_valid <= 0;
    tcnt     <= tcnt + 1;
    stb_prev <= wbm_stb_o;
  end

  task automatic pulse_accum();
    @(negedge correlator_clk) accum_int = 1'b1;
    @(negedge correlator_clk) accum_int = 1'b0;
  endtask

  task automatic clear_irq();
    @(negedge correlator_clk) irq_clr = 1'b1;
    @(negedge correlator_clk) irq_clr = 1'b0;
    chk("irq_cleared", irq, 1'b0);
  endtask

  task automatic wait_irq(input int max, output int t);
    for (int i = 0; i < max; i++) begin
      @(negedge correlator_clk);
      if (irq) break;
    end
    t = tcnt;
    chk("irq_wait", irq, 1'b1);
  endtask

  task automatic rd_chk(input string tag, input int idx, input logic [31:0] exp);
    rd_adr = 4'(idx);
    #1;
    chk($sformatf("%s[%0d]", tag, idx), rd_dat, exp);
  endtask

  function automatic logic [31:0] iq_a(input int i);
    return (i < 6) ? 32'(i + 1) : 32'h77 + 32'(i - 6) * 32'h11;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n0, nr;
    bit seen;
    logic [31:0] ea;
    status_v  = 32'h0000_00C3;
    newdata_v = 32'h1;
    for (int i = 0; i < 10; i++) iq[i] = iq_a(i);

    // reset state
    rstn = 1'b0;
    repeat (3) @(negedge correlator_clk);
    chk("rst_cyc", wbm_cyc_o, 1'b0);
    chk("rst_stb", wbm_stb_o, 1'b0);
    chk("rst_we", wbm_we_o, 1'b0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_sel", wbm_sel_o, 4'hF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ovr", overrun_cnt, 8'h0);
    rd_chk("rst_buf", 0, 32'h0);
    rstn = 1'b1;
    @(negedge correlator_clk);

    // full 12-read sequence
    n0 = nack;
    adr_q.delete();
    pulse_accum();
    wait_irq(300, t);
    chk("seq_acks", 32'(nack - n0), 32'd12);
    chk("seq_adr_count", 32'(adr_q.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      ea = (i == 0) ? 32'h380 : (i == 1) ? 32'h384 : 32'h10 + 32'(4 * (i - 2));
      chk($sformatf("seq_adr[%0d]", i), (i < adr_q.size()) ? adr_q[i] : 32'hFFFF_FFFF, ea);
    end
    chk("seq_irq_latency", 32'(t - last_ack_t), 32'd3);
    chk("seq_gap", 32'(gap_bad), 32'd0);
    chk("seq_busy", busy, 1'b0);
    chk("seq_err", err, 1'b0);
    for (int i = 0; i < 10; i++) rd_chk("seq_buf", i, iq_a(i));
    rd_chk("seq_buf", 10, 32'hC3);
    rd_chk("seq_buf", 11, 32'h1);
    for (int i = 12; i < 16; i++) rd_chk("seq_buf", i, 32'h0);

    // NEW_DATA=0: two reads, I/Q words untouched
    clear_irq();
    newdata_v = 32'h0;
    status_v  = 32'h5A;
    for (int i = 0; i < 10; i++) iq[i] = 32'hFFFF_0000 + 32'(i);
    n0 = nreq;
    pulse_accum();
    wait_irq(300, t);
    chk("nodata_reqs", 32'(nreq - n0), 32'd2);
    for (int i = 0; i < 10; i++) rd_chk("nodata_buf", i, iq_a(i));
    rd_chk("nodata_buf", 10, 32'h5A);
    rd_chk("nodata_buf", 11, 32'h0);

    // overrun counting, no restart afterwards
    clear_irq();
    newdata_v = 32'h1;
    pulse_accum();
    for (int k = 0; k < 3; k++) begin
      repeat (4) @(negedge correlator_clk);
      pulse_accum();
    end
    wait_irq(300, t);
    chk("ovr_cnt", overrun_cnt, 8'd3);
    rd_chk("ovr_buf", 0, 32'hFFFF_0000);
    nr = nreq;
    repeat (20) @(negedge correlator_clk);
    chk("ovr_no_restart", 32'(nreq - nr), 32'd0);
    chk("ovr_idle", busy, 1'b0);

    // reset during WAIT_ACK of step 5
    n0 = nack;
    pulse_accum();
    for (int i = 0; i < 200; i++) begin
      @(negedge correlator_clk);
      if (wbm_stb_o && nack == n0 + 5) break;
    end
    @(negedge correlator_clk);
    chk("mid_stb_before", wbm_stb_o, 1'b1);
    rstn = 1'b0;
    @(negedge correlator_clk);
    chk("mid_cyc", wbm_cyc_o, 1'b0);
    chk("mid_stb", wbm_stb_o, 1'b0);
    chk("mid_adr", wbm_adr_o, 32'h0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_irq", irq, 1'b0);
    chk("mid_err", err, 1'b0);
    chk("mid_ovr", overrun_cnt, 8'h0);
    rd_chk("mid_buf", 0, 32'h0);
    rd_chk("mid_buf", 10, 32'h0);
    rstn = 1'b1;
    @(negedge correlator_clk);

    // bus timeout, irq_clr coincident with DONE then one cycle later
    ack_en = 1'b0;
    seen = 0;
    pulse_accum();
    for (int i = 0; i < 100; i++) begin
      @(negedge correlator_clk);
      if (seen && !wbm_stb_o) break;
      if (wbm_stb_o) seen = 1;
    end
    chk("to_done_busy", busy, 1'b1);
    chk("to_done_err", err, 1'b1);
    chk("to_done_irq", irq, 1'b0);
    irq_clr = 1'b1;
    @(negedge correlator_clk);
    chk("to_stb_len", 32'(last_hi), 32'd16);
    chk("to_irq_set_wins", irq, 1'b1);
    chk("to_err_kept", err, 1'b1);
    chk("to_busy", busy, 1'b0);
    @(negedge correlator_clk);
    irq_clr = 1'b0;
    chk("to_irq_clr", irq, 1'b0);
    chk("to_err_clr", err, 1'b0);
    ack_en = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gps_accum_reader.md
GPS_ACCUM_READER -- requirements
Module: gps_accum_reader

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h0000_0000, base byte address of the correlator register window.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum cycles stb_o is held waiting for ack_i.
REQ-003 SHALL have port correlator_clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low; clock correlator_clk.
REQ-005 SHALL have port accum_int  input  1  correlator accumulation interrupt level.
REQ-006 SHALL have port wbm_adr_o  output  32  Wishbone master byte address.
REQ-007 SHALL have port wbm_dat_i  input  32  Wishbone read data.
REQ-008 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone cycle, strobe, write-enable.
REQ-009 SHALL have port wbm_sel_o  output  4  byte selects, constant 4'hF.
REQ-010 SHALL have port wbm_ack_i  input  1  Wishbone acknowledge.
REQ-011 SHALL have port rd_adr  input  4  snapshot buffer read index.
REQ-012 SHALL have port rd_dat  output  32  snapshot word at rd_adr, combinational.
REQ-013 SHALL have port irq  output  1  snapshot-ready interrupt, sticky.
REQ-014 SHALL have port irq_clr  input  1  single-cycle pulse clearing irq.
REQ-015 SHALL have port busy  output  1  high while a fetch sequence runs.
REQ-016 SHALL have port err  output  1  sticky bus-timeout flag, cleared by irq_clr.
REQ-017 SHALL have port overrun_cnt  output  8  count of accum_int rising edges seen while busy, saturating.

Function
REQ-018 SHALL detect an accum_int rising edge using a registered copy of accum_int.
REQ-019 SHALL implement states IDLE, REQ, WAIT_ACK, GAP, DONE.
REQ-020 IDLE: on a rising edge, SHALL set step index to 0 and go to REQ next cycle.
REQ-021 REQ: SHALL drive cyc_o=stb_o=1, we_o=0, and adr_o=BASE_ADR+{step word address,2'b00}, then go to WAIT_ACK.
REQ-022 Step word addresses SHALL be, in order: 0xE0 STATUS, 0xE1 NEW_DATA, then 0x04..0x0D. This gives 12 steps.
REQ-023 WAIT_ACK: adr/cyc/stb SHALL stay stable until ack_i is seen.
REQ-024 On ack_i, wbm_dat_i SHALL be written to buffer[step] in the same cycle, cyc/stb SHALL drop next cycle, and the FSM SHALL go to GAP.
REQ-025 Buffer mapping: step 0 -> buffer[10] (STATUS), step 1 -> buffer[11] (NEW_DATA), step k>=2 -> buffer[k-2]; buffer[12..15] SHALL read 0.
REQ-026 GAP: cyc/stb SHALL be low for exactly one cycle, guaranteeing the responder returns to idle. Then the FSM SHALL go to REQ with step+1, or to DONE after step 11.
REQ-027 After step 1, if NEW_DATA bit 0 is 0, the FSM SHALL skip steps 2..11 and go to DONE; buffer[0..9] SHALL keep their old values.
REQ-028 DONE: SHALL set irq=1 and go to IDLE next cycle.
REQ-029 busy SHALL be 1 in all states except IDLE.
REQ-030 The WAIT_ACK cycle counter SHALL run from 0. If it reaches TIMEOUT without ack_i: cyc/stb SHALL drop, err=1, and the FSM SHALL go to DONE.
REQ-031 A rising edge of accum_int while busy SHALL increment overrun_cnt, saturating at 255, and SHALL NOT start a new sequence.
REQ-032 If irq_clr and DONE's irq set occur in the same cycle, the set SHALL win.
REQ-033 ack_i outside WAIT_ACK SHALL be ignored.
REQ-034 wbm_dat_o SHALL NOT exist; the block is read-only.

Reset
REQ-035 While rstn=0: state=IDLE, cyc/stb/we=0, adr_o=0, irq=0, err=0, busy=0, overrun_cnt=0, step=0, accum_int edge register=0, all buffer words=0.
REQ-036 Reset asserted mid-transaction SHALL drop cyc/stb on the next edge with no buffer write.

Verification
REQ-037 Responder acks 3 cycles after stb, NEW_DATA=1, early/prompt/late I/Q=0x0001..0x0006: accum_int rises -> 12 reads at byte addresses 0x380, 0x384, 0x010..0x034; buffer[0..5]=1..6; irq=1 after the last ack + GAP.
REQ-038 NEW_DATA=0 -> exactly 2 bus cycles; buffer[0..9] unchanged; irq=1.
REQ-039 Responder never acks -> stb held 16 cycles, then released; err=1, irq=1, busy=0.
REQ-040 accum_int pulsed 3 times during a sequence -> overrun_cnt=3; no restart after DONE without a new edge.
REQ-041 rstn low during WAIT_ACK of step 5 -> cyc/stb=0 next cycle; all outputs at reset values.
REQ-042 irq_clr coincident with DONE -> irq remains 1; irq_clr one cycle later -> irq=0 and err=0.
